// File: rtl/seq_entry_display_if.sv
// Handshake/bus bundle for seq_entry_display: game-phase, tick and button
// inputs plus the segment, entry and result outputs.
interface seq_entry_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int SYM_W      = 2
);
    logic [7:0]                  display;
    logic                        one_sec;
    logic                        button_move;
    logic                        button_next;
    logic [NUM_DIGITS*SYM_W-1:0] sequence_in;
    logic [NUM_DIGITS*7-1:0]     seg_out;
    logic [NUM_DIGITS*SYM_W-1:0] entry_out;
    logic [2:0]                  cursor;
    logic                        result_valid;
    logic                        match;
    logic                        timeout;

    modport master (
        output display, one_sec, button_move, button_next, sequence_in,
        input  seg_out, entry_out, cursor, result_valid, match, timeout
    );

    modport slave (
        input  display, one_sec, button_move, button_next, sequence_in,
        output seg_out, entry_out, cursor, result_valid, match, timeout
    );
endinterface

// File: rtl/seq_entry_display.sv
// Sequence show-and-entry block for the bomb puzzle.
// Shows the target on active-low seven-segment digits for SHOW_SECS ticks,
// then lets the player edit digits MSB-first and flags whether the entry
// matches the target. All outputs are registered.
// Optional macro ENTRY_TIMEOUT_EN adds an inactivity timeout in ENTRY.
module seq_entry_display #(
    parameter int         NUM_DIGITS   = 4,
    parameter int         SYM_W        = 2,
    parameter int         NUM_SYMS     = 4,
    parameter int         SHOW_SECS    = 3,
    parameter logic [7:0] START_CODE   = 8'h10,
    parameter int         TIMEOUT_SECS = 10
) (
    input  logic               clk,
    input  logic               reset,
    seq_entry_display_if.slave bus
);
    localparam int         SEQ_W       = NUM_DIGITS * SYM_W;
    localparam int         SEG_W       = NUM_DIGITS * 7;
    localparam int         SHOW_CW     = $clog2(SHOW_SECS + 1);
    localparam logic [2:0] LAST_DIGIT  = 3'(NUM_DIGITS - 1);
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Parameter ranges the glyph table and cursor width can represent.
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || NUM_SYMS < 2 || NUM_SYMS > 4 ||
        SHOW_SECS < 1 || TIMEOUT_SECS < 1) begin : g_param_check
        $error("seq_entry_display: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHOW       = 3'd1,
        ST_ENTRY_INIT = 3'd2,
        ST_ENTRY      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [SEQ_W-1:0]   entry_q, entry_d;
    logic [2:0]         cursor_q, cursor_d;
    logic [SHOW_CW-1:0] show_cnt_q, show_cnt_d;
    logic               result_valid_q, result_valid_d;
    logic               match_q, match_d;
    logic               timed_out_s;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TO_CW = $clog2(TIMEOUT_SECS + 1);
    logic [TO_CW-1:0] inact_q, inact_d;
    logic             timeout_q, timeout_d;
`endif

    // Symbol index to active-low glyph; indices >= NUM_SYMS are illegal.
    function automatic logic [6:0] glyph(input logic [SYM_W-1:0] sym);
        logic [6:0] g;
        int         idx;
        idx = int'(sym);
        if (idx >= NUM_SYMS) begin
            g = 7'b0100001;
        end else begin
            case (idx[1:0])
                2'd0:    g = 7'b1111110;
                2'd1:    g = 7'b1111001;
                2'd2:    g = 7'b1110111;
                2'd3:    g = 7'b1001111;
                default: g = 7'b0100001;
            endcase
        end
        return g;
    endfunction

    // Whole packed sequence to packed glyphs, digit i to bits [i*7 +: 7].
    function automatic logic [SEG_W-1:0] glyph_row(input logic [SEQ_W-1:0] seq);
        logic [SEG_W-1:0] row;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            row[i*7 +: 7] = glyph(seq[i*SYM_W +: SYM_W]);
        end
        return row;
    endfunction

    // Next-state and next-output computation for the round sequencer.
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        entry_d     = entry_q;
        cursor_d    = cursor_q;
        show_cnt_d  = show_cnt_q;
        match_d     = match_q;
        timed_out_s = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        inact_d     = inact_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                seg_d      = {NUM_DIGITS{GLYPH_BLANK}};
                show_cnt_d = '0;
                if (bus.display == START_CODE) state_d = ST_SHOW;
                else                           state_d = ST_IDLE;
            end
            ST_SHOW: begin
                // The blanked entry is presented already while in ENTRY_INIT,
                // so the clears are applied on the way in as well.
                if (show_cnt_q == SHOW_CW'(SHOW_SECS)) begin
                    state_d  = ST_ENTRY_INIT;
                    entry_d  = '0;
                    cursor_d = LAST_DIGIT;
                    seg_d    = glyph_row({SEQ_W{1'b0}});
                    match_d  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
                    inact_d   = '0;
                    timeout_d = 1'b0;
`endif
                end else begin
                    seg_d = glyph_row(bus.sequence_in);
                    if (bus.one_sec) show_cnt_d = show_cnt_q + SHOW_CW'(1);
                    else             show_cnt_d = show_cnt_q;
                end
            end
            ST_ENTRY_INIT: begin
                state_d  = ST_ENTRY;
                entry_d  = '0;
                cursor_d = LAST_DIGIT;
                seg_d    = glyph_row({SEQ_W{1'b0}});
                match_d  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
                inact_d   = '0;
                timeout_d = 1'b0;
`endif
            end
            ST_ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
                // Any button pulse restarts the inactivity window, even on the final tick.
                if (bus.button_move || bus.button_next) inact_d = '0;
                else if (bus.one_sec)                  inact_d = inact_q + TO_CW'(1);
                else                                   inact_d = inact_q;
                timed_out_s = !bus.button_move && !bus.button_next && bus.one_sec &&
                              (inact_q == TO_CW'(TIMEOUT_SECS - 1));
`endif
                if (timed_out_s) begin
                    state_d = ST_DONE;
                    match_d = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end else if (bus.button_next) begin
                    // next wins over a simultaneous move
                    if (cursor_q == 3'd0) begin
                        state_d = ST_DONE;
                        match_d = (entry_q == bus.sequence_in);
                    end else begin
                        cursor_d = cursor_q - 3'd1;
                    end
                end else if (bus.button_move) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (3'(i) == cursor_q) begin
                            if (entry_q[i*SYM_W +: SYM_W] >= SYM_W'(NUM_SYMS - 1))
                                entry_d[i*SYM_W +: SYM_W] = '0;
                            else
                                entry_d[i*SYM_W +: SYM_W] = entry_q[i*SYM_W +: SYM_W] + SYM_W'(1);
                        end else begin
                            entry_d[i*SYM_W +: SYM_W] = entry_q[i*SYM_W +: SYM_W];
                        end
                    end
                end else begin
                    entry_d = entry_q;
                end
                seg_d = glyph_row(entry_d);
            end
            ST_DONE: begin
                seg_d = glyph_row(entry_q);
                if (bus.button_next) state_d = ST_IDLE;
                else                 state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                seg_d   = {NUM_DIGITS{GLYPH_BLANK}};
            end
        endcase
        result_valid_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            seg_q          <= {NUM_DIGITS{GLYPH_BLANK}};
            entry_q        <= '0;
            cursor_q       <= LAST_DIGIT;
            show_cnt_q     <= '0;
            result_valid_q <= 1'b0;
            match_q        <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            inact_q        <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            seg_q          <= seg_d;
            entry_q        <= entry_d;
            cursor_q       <= cursor_d;
            show_cnt_q     <= show_cnt_d;
            result_valid_q <= result_valid_d;
            match_q        <= match_d;
`ifdef ENTRY_TIMEOUT_EN
            inact_q        <= inact_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign bus.seg_out      = seg_q;
    assign bus.entry_out    = entry_q;
    assign bus.cursor       = cursor_q;
    assign bus.result_valid = result_valid_q;
    assign bus.match        = match_q;
`ifdef ENTRY_TIMEOUT_EN
    assign bus.timeout      = timeout_q;
`else
    assign bus.timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_entry_display.sv
// Self-checking bench for seq_entry_display: directed steps from the test
// plan followed by randomized rounds, all compared every cycle against a
// phase-level reference model of the round rules.
`timescale 1ns/1ps
module tb_seq_entry_display;
    localparam int         ND    = 4;
    localparam int         SW    = 2;
    localparam int         NS    = 4;
    localparam int         SHOW  = 3;
    localparam int         TOUT  = 10;
    localparam logic [7:0] START = 8'h10;
    localparam logic [6:0] BLANK = 7'b1111111;

    localparam int P_IDLE = 0, P_SHOW = 1, P_INIT = 2, P_ENTRY = 3, P_DONE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    seq_entry_display_if #(.NUM_DIGITS(ND), .SYM_W(SW)) bus ();

    seq_entry_display #(
        .NUM_DIGITS(ND), .SYM_W(SW), .NUM_SYMS(NS), .SHOW_SECS(SHOW),
        .START_CODE(START), .TIMEOUT_SECS(TOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model
    logic [6:0]      glyph_tab [5] = '{7'b1111110, 7'b1111001, 7'b1110111, 7'b1001111, 7'b0100001};
    int              m_phase;
    int              m_entry [ND];
    int              m_cur;
    int              m_cnt;
    int              m_inact;
    bit              m_match;
    bit              m_timeout;
    logic [ND*7-1:0] m_seg;

    function automatic logic [ND*7-1:0] glyphs_of(input logic [ND*SW-1:0] v);
        logic [ND*7-1:0] r;
        for (int i = 0; i < ND; i++) begin
            int s = int'(v[i*SW +: SW]);
            r[i*7 +: 7] = (s < NS) ? glyph_tab[s] : glyph_tab[4];
        end
        return r;
    endfunction

    function automatic logic [ND*SW-1:0] entry_vec();
        logic [ND*SW-1:0] v;
        for (int i = 0; i < ND; i++) v[i*SW +: SW] = SW'(m_entry[i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".seg"},    64'(bus.seg_out),      64'(m_seg));
        check({tag, ".entry"},  64'(bus.entry_out),    64'(entry_vec()));
        check({tag, ".cursor"}, 64'(bus.cursor),       64'(m_cur));
        check({tag, ".valid"},  64'(bus.result_valid), 64'(m_phase == P_DONE));
        check({tag, ".match"},  64'(bus.match),        64'(m_match));
        check({tag, ".tmo"},    64'(bus.timeout),      64'(m_timeout));
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_cur = ND - 1; m_cnt = 0; m_inact = 0;
        m_match = 1'b0; m_timeout = 1'b0; m_seg = {ND{BLANK}};
        for (int i = 0; i < ND; i++) m_entry[i] = 0;
    endtask

    // One clock with the given inputs; model advanced by the round rules, then all outputs checked.
    task automatic step(input bit mv, input bit nx, input bit sec, input logic [7:0] disp);
        int               old;
        bit               timed_out;
        logic [ND*SW-1:0] tgt;
        bus.button_move = mv; bus.button_next = nx; bus.one_sec = sec; bus.display = disp;
        tgt = bus.sequence_in;
        @(posedge clk); #1;
        bus.button_move = 1'b0; bus.button_next = 1'b0; bus.one_sec = 1'b0;
        old = m_phase;
        timed_out = 1'b0;
        case (old)
            P_IDLE: begin
                m_cnt = 0;
                if (disp == START) m_phase = P_SHOW;
            end
            P_SHOW: begin
                if (m_cnt == SHOW) begin
                    m_phase = P_INIT; m_cur = ND - 1; m_match = 1'b0; m_timeout = 1'b0; m_inact = 0;
                    for (int i = 0; i < ND; i++) m_entry[i] = 0;
                end else if (sec) m_cnt++;
            end
            P_INIT: m_phase = P_ENTRY;
            P_ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
                if (mv || nx) m_inact = 0;
                else if (sec) begin
                    m_inact++;
                    if (m_inact == TOUT) timed_out = 1'b1;
                end
`endif
                if (timed_out) begin
                    m_phase = P_DONE; m_match = 1'b0; m_timeout = 1'b1;
                end else if (nx) begin
                    if (m_cur == 0) begin
                        m_phase = P_DONE; m_match = (entry_vec() == tgt);
                    end else m_cur--;
                end else if (mv) m_entry[m_cur] = (m_entry[m_cur] + 1) % NS;
            end
            P_DONE: if (nx) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
        endcase
        if (old == P_IDLE) m_seg = {ND{BLANK}};
        else if (old == P_SHOW && m_phase == P_SHOW) m_seg = glyphs_of(tgt);
        else m_seg = glyphs_of(entry_vec());
        check_all("cyc");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        check_all("reset");
    endtask

    task automatic start_round(input logic [ND*SW-1:0] target);
        bus.sequence_in = target;
        step(1'b0, 1'b0, 1'b0, START);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < SHOW; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [ND*7-1:0] seg_e4;
        bit              aim;
        int              guard;
        seg_e4 = {7'b1001111, 7'b1110111, 7'b1111001, 7'b1111110};
        bus.display = 8'h00; bus.one_sec = 1'b0; bus.button_move = 1'b0;
        bus.button_next = 1'b0; bus.sequence_in = 8'hE4;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        check("reset_seg_blank", 64'(bus.seg_out), 64'(28'hFFFFFFF));
        check("reset_cursor",    64'(bus.cursor),  64'(3));

        // Show timing with 1-cycle glyph latency; buttons in SHOW ignored.
        bus.sequence_in = 8'hE4;
        step(1'b0, 1'b0, 1'b0, START);
        check("show_latency_blank", 64'(bus.seg_out), 64'(28'hFFFFFFF));
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check("show_glyphs", 64'(bus.seg_out), 64'(seg_e4));
        for (int i = 0; i < SHOW; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, START);
        check("init_sym0", 64'(bus.seg_out), 64'({ND{7'b1111110}}));
        check("init_cursor", 64'(bus.cursor), 64'(3));
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Correct entry of 8'hE4.
        for (int d = 3; d >= 0; d--) begin
            for (int k = 0; k < d; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check("ok_valid", 64'(bus.result_valid), 64'(1));
        check("ok_match", 64'(bus.match),        64'(1));
        check("ok_entry", 64'(bus.entry_out),    64'(8'hE4));
        step(1'b0, 1'b0, 1'b0, START);
        check("done_holds_seg", 64'(bus.seg_out), 64'(seg_e4));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("idle_valid_clr", 64'(bus.result_valid), 64'(0));
        check("idle_match_kept", 64'(bus.match), 64'(1));
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Wrap and move/next priority.
        start_round(8'(($urandom)));
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap_entry", 64'(bus.entry_out), 64'(0));
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check("prio_cursor", 64'(bus.cursor), 64'(2));
        check("prio_entry",  64'(bus.entry_out), 64'(0));

        // Reset mid-entry with cursor=1.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        do_reset();
        check("mid_reset_entry", 64'(bus.entry_out), 64'(0));
        check("mid_reset_cursor", 64'(bus.cursor), 64'(3));

        // Mismatch, then restart.
        start_round(8'hE4);
        for (int k = 0; k < ND; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
        check("mis_valid", 64'(bus.result_valid), 64'(1));
        check("mis_match", 64'(bus.match), 64'(0));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, START);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("restart_show", 64'(bus.seg_out), 64'(seg_e4));
        for (int i = 0; i < SHOW + 2; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

`ifdef ENTRY_TIMEOUT_EN
        // Finish the current round, then exercise the inactivity timeout.
        for (int k = 0; k < ND + 1; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
        start_round(8'h1B);
        for (int k = 0; k < TOUT - 1; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check("tmo_not_yet", 64'(bus.result_valid), 64'(0));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("tmo_flag",  64'(bus.timeout), 64'(1));
        check("tmo_valid", 64'(bus.result_valid), 64'(1));
        check("tmo_match", 64'(bus.match), 64'(0));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        start_round(8'h1B);
        check("tmo_cleared", 64'(bus.timeout), 64'(0));
        for (int k = 0; k < TOUT - 1; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("tmo_button_wins", 64'(bus.timeout), 64'(0));
        check("tmo_btn_valid", 64'(bus.result_valid), 64'(0));
`endif
        // Drain back to IDLE before random rounds.
        guard = 0;
        while (m_phase != P_IDLE && guard < 20) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            guard++;
        end

        // Randomized rounds; half of them steer the entry toward the target.
        for (int r = 0; r < 24; r++) begin
            aim = r[0];
            bus.sequence_in = 8'($urandom);
            step(1'b0, 1'b0, 1'b0, START);
            guard = 0;
            while (m_phase != P_DONE && guard < 400) begin
                bit mv, nx, sec;
                logic [7:0] disp;
                sec  = ($urandom_range(0, 3) == 0);
                disp = ($urandom_range(0, 4) == 0) ? START : 8'($urandom);
                if (m_phase == P_SHOW && $urandom_range(0, 9) == 0) bus.sequence_in = 8'($urandom);
                if (aim && m_phase == P_ENTRY) begin
                    mv = (m_entry[m_cur] != int'(bus.sequence_in[m_cur*SW +: SW]));
                    nx = !mv;
                end else begin
                    mv = ($urandom_range(0, 2) == 0);
                    nx = ($urandom_range(0, 4) == 0);
                end
                step(mv, nx, sec, disp);
                guard++;
            end
            check("round_done", 64'(bus.result_valid), 64'(1));
            step(1'b0, 1'b0, 1'b1, START);
            step(1'b0, 1'b1, 1'b0, START);
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
